// File: rtl/sensor_pkg.sv
// Shared types and default constants for the sensor monitor slice.
package sensor_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUALIFY = 2'd1,
    S_FAULT   = 2'd2
  } state_t;

  localparam logic [3:0] DEF_CRIT_MASK = 4'b0001;
  localparam logic [3:0] DEF_PAIR_MASK = 4'b1100;

endpackage

// File: rtl/sensor_sync.sv
// Two-flop synchroniser for a vector of asynchronous level inputs.
module sensor_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/sensor_monitor.sv
// Sensor fault detector: synchronise, apply fault rule, qualify over PERSIST
// cycles, latch a sticky error released only by a clear handshake.
module sensor_monitor
  import sensor_pkg::*;
#(
  parameter int unsigned                 NUM_SENSORS = 4,
  parameter logic [NUM_SENSORS-1:0]      CRIT_MASK   = NUM_SENSORS'(DEF_CRIT_MASK),
  parameter int unsigned                 GATE_IDX    = 1,
  parameter logic [NUM_SENSORS-1:0]      PAIR_MASK   = NUM_SENSORS'(DEF_PAIR_MASK),
  parameter int unsigned                 PERSIST     = 3,
  parameter int unsigned                 CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SENSORS-1:0] sensors,
  input  logic                   clear_req,
  output logic                   error,
  output logic                   clear_ack,
  output logic [NUM_SENSORS-1:0] fault_vec,
  output logic [CNT_W-1:0]       fault_count
);

  localparam int unsigned             CNT_BITS = $clog2(PERSIST + 1);
  localparam logic [CNT_BITS-1:0]     CNT_LAST = CNT_BITS'(PERSIST - 1);

  if (GATE_IDX >= NUM_SENSORS) begin : g_bad_gate
    $error("sensor_monitor: GATE_IDX must be below NUM_SENSORS");
  end
  if (NUM_SENSORS < 2) begin : g_bad_num
    $error("sensor_monitor: NUM_SENSORS must be at least 2");
  end
  if (PERSIST < 1) begin : g_bad_persist
    $error("sensor_monitor: PERSIST must be at least 1");
  end

  logic [NUM_SENSORS-1:0] w_sync;
  logic                   w_fault;

  state_t                 r_state, w_state_nxt;
  logic [CNT_BITS-1:0]    r_cnt, w_cnt_nxt;
  logic                   r_error, w_error_nxt;
  logic                   r_clear_ack, w_clear_ack_nxt;
  logic [NUM_SENSORS-1:0] r_fault_vec, w_fault_vec_nxt;
  logic [CNT_W-1:0]       r_fault_count, w_fault_count_nxt;
  logic                   w_enter;

  sensor_sync #(.WIDTH(NUM_SENSORS)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (sensors),
    .o_sync  (w_sync)
  );

  assign w_fault = (|(w_sync & CRIT_MASK)) |
                   (w_sync[GATE_IDX] & (|(w_sync & PAIR_MASK)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_error       <= 1'b0;
      r_clear_ack   <= 1'b0;
      r_fault_vec   <= '0;
      r_fault_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_error       <= w_error_nxt;
      r_clear_ack   <= w_clear_ack_nxt;
      r_fault_vec   <= w_fault_vec_nxt;
      r_fault_count <= w_fault_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_error_nxt       = r_error;
    w_clear_ack_nxt   = 1'b0;
    w_fault_vec_nxt   = r_fault_vec;
    w_fault_count_nxt = r_fault_count;
    w_enter           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_fault) begin
          if (PERSIST == 1) begin
            w_enter = 1'b1;
          end else begin
            w_state_nxt = S_QUALIFY;
            w_cnt_nxt   = CNT_BITS'(1);
          end
        end
      end
      S_QUALIFY: begin
        if (!w_fault) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_enter = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_BITS'(1);
        end
      end
      S_FAULT: begin
        // A clear is only honoured once the fault has gone; fault_count survives.
        if (clear_req && !w_fault) begin
          w_state_nxt     = S_IDLE;
          w_error_nxt     = 1'b0;
          w_clear_ack_nxt = 1'b1;
          w_fault_vec_nxt = '0;
          w_cnt_nxt       = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_enter) begin
      w_state_nxt     = S_FAULT;
      w_cnt_nxt       = '0;
      w_error_nxt     = 1'b1;
      w_fault_vec_nxt = w_sync;
      if (r_fault_count != '1) begin
        w_fault_count_nxt = r_fault_count + CNT_W'(1);
      end
    end
  end

  assign error       = r_error;
  assign clear_ack   = r_clear_ack;
  assign fault_vec   = r_fault_vec;
  assign fault_count = r_fault_count;

endmodule

// File: tb/tb_sensor_monitor.sv
// Scoreboard bench: three monitor variants (default, CNT_W=2, PERSIST=1)
// driven by shared stimulus and checked each cycle against a reference model.
module tb_sensor_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sensors = 4'h0;
  logic       clear_req = 1'b0;

  always #5 clk = ~clk;

  logic       err [3];
  logic       ack [3];
  logic [3:0] vec [3];
  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;

  sensor_monitor u_def (
    .clk(clk), .rst(rst), .sensors(sensors), .clear_req(clear_req),
    .error(err[0]), .clear_ack(ack[0]), .fault_vec(vec[0]), .fault_count(cnt0)
  );

  sensor_monitor #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .sensors(sensors), .clear_req(clear_req),
    .error(err[1]), .clear_ack(ack[1]), .fault_vec(vec[1]), .fault_count(cnt1)
  );

  sensor_monitor #(.PERSIST(1)) u_p1 (
    .clk(clk), .rst(rst), .sensors(sensors), .clear_req(clear_req),
    .error(err[2]), .clear_ack(ack[2]), .fault_vec(vec[2]), .fault_count(cnt2)
  );

  typedef struct packed {
    logic       err;
    logic       ack;
    logic [3:0] vec;
    logic [7:0] cnt;
  } exp_t;
  typedef exp_t [2:0] exp3_t;

  exp3_t scb[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference model: synchroniser as a 2-deep delay line, qualification as a
  // streak of consecutive faulty cycles, error as a sticky flag.
  int         P    [3] = '{3, 3, 1};
  int         CMAX [3] = '{255, 3, 255};
  logic [3:0] m_meta, m_sync;
  int         m_streak [3];
  logic       m_err [3];
  logic       m_ack [3];
  logic [3:0] m_vec [3];
  int         m_cnt [3];

  function automatic logic rule(input logic [3:0] s);
    return s[0] | (s[1] & (s[2] | s[3]));
  endfunction

  task automatic check(input string name, input int inst,
                       input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t got=%0h want=%0h", name, inst, $time, got, want);
    end
  endtask

  task automatic model_edge();
    exp3_t e;
    if (rst) begin
      m_meta = 4'h0;
      m_sync = 4'h0;
      for (int i = 0; i < 3; i++) begin
        m_streak[i] = 0; m_err[i] = 1'b0; m_ack[i] = 1'b0;
        m_vec[i] = 4'h0; m_cnt[i] = 0;
      end
    end else begin
      logic f;
      f = rule(m_sync);
      for (int i = 0; i < 3; i++) begin
        m_ack[i] = 1'b0;
        if (!m_err[i]) begin
          m_streak[i] = f ? m_streak[i] + 1 : 0;
          if (m_streak[i] >= P[i]) begin
            m_err[i]    = 1'b1;
            m_vec[i]    = m_sync;
            m_cnt[i]    = (m_cnt[i] < CMAX[i]) ? m_cnt[i] + 1 : m_cnt[i];
            m_streak[i] = 0;
          end
        end else if (clear_req && !f) begin
          m_err[i]    = 1'b0;
          m_ack[i]    = 1'b1;
          m_vec[i]    = 4'h0;
          m_streak[i] = 0;
        end
      end
      m_sync = m_meta;
      m_meta = sensors;
    end
    for (int i = 0; i < 3; i++) begin
      e[i].err = m_err[i];
      e[i].ack = m_ack[i];
      e[i].vec = m_vec[i];
      e[i].cnt = 8'(m_cnt[i]);
    end
    scb.push_back(e);
  endtask

  task automatic step(input logic [3:0] s, input logic c);
    @(negedge clk);
    sensors   = s;
    clear_req = c;
    model_edge();
    @(posedge clk);
  endtask

  task automatic hold(input logic [3:0] s, input logic c, input int n);
    for (int k = 0; k < n; k++) step(s, c);
  endtask

  task automatic clear_fault();
    hold(4'h0, 1'b0, 3);
    step(4'h0, 1'b1);
    step(4'h0, 1'b0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_err0", 0, 8'(err[0]), 8'h0);
    check("rst_ack0", 0, 8'(ack[0]), 8'h0);
    check("rst_vec0", 0, 8'(vec[0]), 8'h0);
    check("rst_cnt0", 0, cnt0, 8'h0);
    check("rst_cnt1", 1, 8'(cnt1), 8'h0);
    check("rst_err2", 2, 8'(err[2]), 8'h0);
    step(sensors, clear_req);
    #2 rst = 1'b0;
  endtask

  // Monitor: every output cycle pops one expectation and compares all variants.
  initial begin
    exp3_t      e;
    logic [7:0] gotc [3];
    forever begin
      @(posedge clk);
      #1;
      if (scb.size() != 0) begin
        e = scb.pop_front();
        gotc[0] = cnt0;
        gotc[1] = 8'(cnt1);
        gotc[2] = cnt2;
        for (int i = 0; i < 3; i++) begin
          check("error",       i, 8'(err[i]), 8'(e[i].err));
          check("clear_ack",   i, 8'(ack[i]), 8'(e[i].ack));
          check("fault_vec",   i, 8'(vec[i]), 8'(e[i].vec));
          check("fault_count", i, gotc[i],    e[i].cnt);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pats [8];
    logic [3:0] s;
    int         pick, len;
    pats = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h6, 4'hA, 4'hC};

    hold(4'h0, 1'b0, 2);
    #2 rst = 1'b0;

    // Critical sensor alone, then release through handshake
    hold(4'h1, 1'b0, 8);
    clear_fault();
    // Short pair glitch, partner without gate, gate alone
    hold(4'h6, 1'b0, 2);
    hold(4'h0, 1'b0, 6);
    hold(4'h4, 1'b0, 10);
    hold(4'h2, 1'b0, 10);
    hold(4'h0, 1'b0, 3);
    // Clear while the fault persists is ignored; held clear acks once
    hold(4'hA, 1'b0, 6);
    hold(4'hA, 1'b1, 2);
    hold(4'h0, 1'b0, 2);
    hold(4'h0, 1'b1, 3);
    hold(4'h0, 1'b0, 2);
    // Async reset mid-qualify and mid-fault
    hold(4'h1, 1'b0, 3);
    async_reset();
    hold(4'h1, 1'b0, 7);
    async_reset();
    hold(4'h1, 1'b0, 7);
    clear_fault();
    // Repeated fault/clear to saturate the narrow counter
    for (int r = 0; r < 5; r++) begin
      hold(4'h1, 1'b0, 6);
      clear_fault();
    end
    // Fault returning on the accepting edge: clear wins
    hold(4'h1, 1'b0, 6);
    hold(4'h0, 1'b0, 2);
    step(4'h1, 1'b1);
    hold(4'h1, 1'b0, 6);
    clear_fault();

    for (int k = 0; k < 80; k++) begin
      pick = $urandom_range(0, 8);
      s    = (pick == 8) ? 4'($urandom) : pats[pick];
      len  = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) step(s, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 24) == 0) async_reset();
    end

    hold(4'h0, 1'b0, 3);
    @(posedge clk);
    #2;
    check("scb_drain", 0, 8'(scb.size()), 8'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
